// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, functs,
// ULA operation codes, datapath select encodings and FSM state encodings.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_QUATRO  = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PC_ULA    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    INICIO    = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    EXEC_R    = 4'd3,
    R_WB      = 4'd4,
    MEMADDR   = 4'd5,
    MEMREAD   = 4'd6,
    MEM_WB    = 4'd7,
    MEMWRITE  = 4'd8,
    BRANCH    = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11,
    JUMP      = 4'd12,
    ILEGAL    = 4'd13
  } estado_t;

endpackage

// File: rtl/ula_controle.sv
// Combinational R-type funct decode: ULA operation plus an unsupported-funct flag.
module ula_controle
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] aluOpCode,
  output logic       functIlegal
);

  always_comb begin
    aluOpCode   = ALU_ADD;
    functIlegal = 1'b0;
    case (funct)
      FN_ADD:  aluOpCode = ALU_ADD;
      FN_SUB:  aluOpCode = ALU_SUB;
      FN_AND:  aluOpCode = ALU_AND;
      FN_OR:   aluOpCode = ALU_OR;
      FN_SLT:  aluOpCode = ALU_SLT;
      default: functIlegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control FSM. Outputs are decoded from the state register so
// an asynchronous reset drops every strobe immediately.
module controle_multiciclo
  import mips_pkg::*;
#(
  parameter int LARGURA_ESTADO = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [5:0]                opcode,
  input  logic [5:0]                funct,
  input  logic                      isZero,
  input  logic                      memReady,
  output logic [2:0]                aluOpCode,
  output logic                      aluSrcA,
  output logic [1:0]                aluSrcB,
  output logic [1:0]                pcSource,
  output logic                      pcEn,
  output logic                      iorD,
  output logic                      memRead,
  output logic                      memWrite,
  output logic                      irWrite,
  output logic                      regDst,
  output logic                      memToReg,
  output logic                      regWrite,
  output logic                      illegal,
  output logic [LARGURA_ESTADO-1:0] estado
);

  estado_t    est;
  logic [2:0] functOp;
  logic       functIlegal;

  ula_controle u_ula_controle (
    .funct       (funct),
    .aluOpCode   (functOp),
    .functIlegal (functIlegal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      est <= INICIO;
    end else begin
      case (est)
        INICIO:    est <= FETCH;
        FETCH:     if (memReady) est <= DECODE;
        DECODE: begin
          case (opcode)
            OP_RTYPE:       est <= functIlegal ? ILEGAL : EXEC_R;
            OP_LW, OP_SW:   est <= MEMADDR;
            OP_BEQ, OP_BNE: est <= BRANCH;
            OP_ADDI:        est <= ADDI_EXEC;
            OP_J:           est <= JUMP;
            default:        est <= ILEGAL;
          endcase
        end
        EXEC_R:    est <= R_WB;
        MEMADDR:   est <= (opcode == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:   if (memReady) est <= MEM_WB;
        MEMWRITE:  if (memReady) est <= FETCH;
        ADDI_EXEC: est <= ADDI_WB;
        R_WB, MEM_WB, BRANCH, ADDI_WB, JUMP, ILEGAL: est <= FETCH;
        default:   est <= INICIO;
      endcase
    end
  end

  always_comb begin
    aluOpCode = ALU_ADD;
    aluSrcA   = 1'b0;
    aluSrcB   = SRCB_REGB;
    pcSource  = PC_ULA;
    pcEn      = 1'b0;
    iorD      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    regDst    = 1'b0;
    memToReg  = 1'b0;
    regWrite  = 1'b0;
    illegal   = 1'b0;
    case (est)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_QUATRO;
        irWrite = memReady;
        pcEn    = memReady;
      end
      // Precompute the branch target into ALUOut while the opcode is decoded.
      DECODE:    aluSrcB = SRCB_IMM_SL2;
      EXEC_R: begin
        aluSrcA   = 1'b1;
        aluOpCode = functOp;
      end
      R_WB: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
      end
      MEMADDR, ADDI_EXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        iorD    = 1'b1;
        memRead = 1'b1;
      end
      MEM_WB: begin
        memToReg = 1'b1;
        regWrite = 1'b1;
      end
      MEMWRITE: begin
        iorD     = 1'b1;
        memWrite = 1'b1;
      end
      BRANCH: begin
        aluSrcA   = 1'b1;
        aluOpCode = ALU_SUB;
        pcSource  = PC_ALUOUT;
        pcEn      = (opcode == OP_BNE) ? !isZero : isZero;
      end
      ADDI_WB:   regWrite = 1'b1;
      JUMP: begin
        pcSource = PC_JUMP;
        pcEn     = 1'b1;
      end
      ILEGAL:    illegal = 1'b1;
      default:   ;
    endcase
  end

  assign estado = LARGURA_ESTADO'(est);

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized scoreboard bench: per-instruction cycle sequences are derived from
// the instruction semantics and checked cycle by cycle by an independent monitor.
module tb_controle_multiciclo;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu;
    logic       srcA;
    logic [1:0] srcB;
    logic [1:0] pcs;
    logic       pcEn, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, illegal;
  } obs_t;

  logic       clock = 1'b0, reset = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic       isZero = 1'b0, memReady = 1'b0;
  logic [2:0] aluOpCode;
  logic       aluSrcA, pcEn, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, illegal;
  logic [1:0] aluSrcB, pcSource;
  logic [3:0] estado;

  controle_multiciclo #(.LARGURA_ESTADO(4)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .isZero(isZero),
    .memReady(memReady), .aluOpCode(aluOpCode), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .pcSource(pcSource), .pcEn(pcEn), .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
    .irWrite(irWrite), .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
    .illegal(illegal), .estado(estado)
  );

  always #5 clock = ~clock;

  obs_t expq[$];
  obs_t act, em;
  int   checks = 0, errors = 0, ncyc = 0;

  assign act = {estado, aluOpCode, aluSrcA, aluSrcB, pcSource, pcEn, iorD, memRead,
                memWrite, irWrite, regDst, memToReg, regWrite, illegal};

  always @(negedge clock) begin
    if (expq.size() > 0) begin
      em = expq.pop_front();
      checks++;
      if (act !== em) begin
        errors++;
        $display("FAIL cycle %0d: got %h (estado %0d) expected %h (estado %0d)",
                 ncyc, act, act.st, em, em.st);
      end
      ncyc++;
    end
  end

  // Reference: the state numbering and per-step control values of each instruction.
  localparam int S_INI = 0, S_FET = 1, S_DEC = 2, S_EXR = 3, S_RWB = 4, S_MAD = 5, S_MRD = 6,
                 S_MWB = 7, S_MWR = 8, S_BR = 9, S_AEX = 10, S_AWB = 11, S_JMP = 12, S_ILG = 13;

  function automatic obs_t base(input int st);
    obs_t o = '0;
    o.st  = 4'(st);
    o.alu = 3'b010;
    return o;
  endfunction

  function automatic int r_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return 2;
      6'h22:   return 6;
      6'h24:   return 0;
      6'h25:   return 1;
      6'h2A:   return 7;
      default: return -1;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic cyc(input logic mr, input logic iz, input obs_t e);
    memReady = mr;
    isZero   = iz;
    expq.push_back(e);
    @(posedge clock); #1;
  endtask

  task automatic do_fetch_decode(input logic [5:0] op, input logic [5:0] fn, input int fw);
    obs_t o;
    o = base(S_FET); o.memRead = 1; o.srcB = 2'b01;
    for (int i = 0; i < fw; i++) cyc(1'b0, rb(), o);
    o.irWrite = 1; o.pcEn = 1;
    cyc(1'b1, rb(), o);
    opcode = op;
    funct  = fn;
    o = base(S_DEC); o.srcB = 2'b11;
    cyc(rb(), rb(), o);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, input logic iz);
    obs_t o;
    int   a;
    do_fetch_decode(op, fn, fw);
    a = r_alu(fn);
    if (op == 6'h00 && a >= 0) begin
      o = base(S_EXR); o.srcA = 1; o.srcB = 2'b00; o.alu = 3'(a);
      cyc(rb(), rb(), o);
      o = base(S_RWB); o.regDst = 1; o.regWrite = 1;
      cyc(rb(), rb(), o);
    end else if (op == 6'h23 || op == 6'h2B) begin
      o = base(S_MAD); o.srcA = 1; o.srcB = 2'b10;
      cyc(rb(), rb(), o);
      if (op == 6'h23) begin
        o = base(S_MRD); o.iorD = 1; o.memRead = 1;
      end else begin
        o = base(S_MWR); o.iorD = 1; o.memWrite = 1;
      end
      for (int i = 0; i < mw; i++) cyc(1'b0, rb(), o);
      cyc(1'b1, rb(), o);
      if (op == 6'h23) begin
        o = base(S_MWB); o.memToReg = 1; o.regWrite = 1;
        cyc(rb(), rb(), o);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      o = base(S_BR); o.srcA = 1; o.alu = 3'b110; o.pcs = 2'b01;
      o.pcEn = (op == 6'h04) ? iz : !iz;
      cyc(rb(), iz, o);
    end else if (op == 6'h08) begin
      o = base(S_AEX); o.srcA = 1; o.srcB = 2'b10;
      cyc(rb(), rb(), o);
      o = base(S_AWB); o.regWrite = 1;
      cyc(rb(), rb(), o);
    end else if (op == 6'h02) begin
      o = base(S_JMP); o.pcs = 2'b10; o.pcEn = 1;
      cyc(rb(), rb(), o);
    end else begin
      o = base(S_ILG); o.illegal = 1;
      cyc(rb(), rb(), o);
    end
  endtask

  task automatic reset_mid_memwrite();
    obs_t o;
    do_fetch_decode(6'h2B, 6'h00, 0);
    o = base(S_MAD); o.srcA = 1; o.srcB = 2'b10;
    cyc(rb(), rb(), o);
    o = base(S_MWR); o.iorD = 1; o.memWrite = 1;
    memReady = 1'b0;
    expq.push_back(o);
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    checks++;
    if (memWrite !== 1'b0 || estado !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: memWrite=%b estado=%0d required memWrite=0 estado=0",
               memWrite, estado);
    end
    @(posedge clock); #1;
    cyc(rb(), rb(), base(S_INI));
    reset = 1'b0;
    cyc(rb(), rb(), base(S_INI));
  endtask

  initial begin
    logic [5:0] lf[5];
    logic [5:0] op, fn;
    int         k;
    lf = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    @(posedge clock); #1;
    cyc(1'b0, 1'b0, base(S_INI));
    cyc(1'b1, 1'b1, base(S_INI));
    reset = 1'b0;
    cyc(rb(), rb(), base(S_INI));

    run_instr(6'h00, 6'h20, 0, 0, 0);
    run_instr(6'h23, 6'h00, 0, 3, 0);
    run_instr(6'h04, 6'h00, 0, 0, 1);
    run_instr(6'h04, 6'h00, 0, 0, 0);
    run_instr(6'h05, 6'h00, 0, 0, 1);
    run_instr(6'h05, 6'h00, 0, 0, 0);
    run_instr(6'h00, 6'h2A, 0, 0, 0);
    run_instr(6'h00, 6'h22, 0, 0, 0);
    run_instr(6'h00, 6'h24, 0, 0, 0);
    run_instr(6'h00, 6'h25, 0, 0, 0);
    run_instr(6'h00, 6'h3F, 0, 0, 0);
    run_instr(6'h3F, 6'h20, 0, 0, 0);
    run_instr(6'h02, 6'h00, 2, 0, 0);
    run_instr(6'h08, 6'h00, 1, 0, 0);
    run_instr(6'h2B, 6'h00, 0, 2, 0);
    reset_mid_memwrite();

    for (int n = 0; n < 200; n++) begin
      k  = $urandom_range(0, 7);
      fn = 6'($urandom);
      case (k)
        0:       begin op = 6'h00; fn = lf[$urandom_range(0, 4)]; end
        1:       op = 6'h00;
        2:       op = 6'h23;
        3:       op = 6'h2B;
        4:       op = 6'h04;
        5:       op = 6'h05;
        6:       op = rb() ? 6'h08 : 6'h02;
        default: op = 6'($urandom);
      endcase
      run_instr(op, fn, rb() ? 0 : $urandom_range(1, 3), rb() ? 0 : $urandom_range(1, 4), rb());
    end

    @(negedge clock); #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
